// File: rtl/trace_snap_pkg.sv
// rtl/trace_snap_pkg.sv - shared constants and helpers for the trace snapshot AXI reader
package trace_snap_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam int DROP_CNT_W = 16;

  function automatic int beats(input int rec_w, input int data_w);
    return (rec_w + data_w - 1) / data_w;
  endfunction

  // Status beat, LSB first: bp, then fill_level, then drop_cnt, zeros above.
  function automatic logic [63:0] status_word(input logic [15:0] drop, input logic [15:0] fill,
                                              input logic [15:0] bp, input int fill_w, input int bp_w);
    return ({48'b0, drop} << (fill_w + bp_w)) | ({48'b0, fill} << bp_w) | {48'b0, bp};
  endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// rtl/snapshot_fifo.sv - DEPTH x W record FIFO with wrap-bit pointers and next-cycle head view
module snapshot_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     head,
  output logic [W-1:0]     head_nxt,
  output logic [PTR_W-1:0] count,
  output logic [PTR_W-1:0] count_nxt,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt
);
  localparam int IDX_W = PTR_W - 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
    end
  end

  assign count     = wr_q - rd_q;
  assign count_nxt = wr_d - rd_d;
  assign full      = (count == PTR_W'(DEPTH));
  assign empty     = (wr_q == rd_q);
  assign empty_nxt = (wr_d == rd_d);
  assign head      = mem_q[rd_q[IDX_W-1:0]];
  // A record being written this cycle into the slot that becomes the head is not in mem_q yet.
  assign head_nxt  = (push && (rd_d[IDX_W-1:0] == wr_q[IDX_W-1:0])) ? wr_data
                                                                     : mem_q[rd_d[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trace_snapshot_axi_reader.sv
// rtl/trace_snapshot_axi_reader.sv - trace record snapshot FIFO drained over AXI4 read bursts
module trace_snapshot_axi_reader
  import trace_snap_pkg::*;
#(
  parameter int REC_W  = 1664,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int ID_W   = 16
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_areset,
  input  logic                       en,
  input  logic                       snap_valid,
  input  logic [REC_W-1:0]           snap_data,
  output logic                       snap_drop,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [ID_W-1:0]            s_axi_arid,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [ID_W-1:0]            s_axi_rid,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready
);
  localparam int BEATS  = beats(REC_W, DATA_W);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int BP_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  state_q, state_d, mode_q, mode_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [BP_W-1:0]       bp_q, bp_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  snap_drop_q, snap_drop_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_W-1:0]       rid_q, rid_d;

  logic accept, beat_done, beat_ok, push, pop, flush, drop, nxt_mode;
  logic [REC_W-1:0]        unused_head, head_nxt;
  logic [FILL_W-1:0]       count, count_nxt;
  logic                    full, unused_empty, empty_nxt, unused_araddr;
  logic [BEATS*DATA_W-1:0] head_pad;
  logic [DATA_W-1:0]       stat_beat;

  snapshot_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(s_axi_aclk), .rst(s_axi_areset), .flush(flush), .push(push), .pop(pop),
    .wr_data(snap_data), .head(unused_head), .head_nxt(head_nxt), .count(count),
    .count_nxt(count_nxt), .full(full), .empty(unused_empty), .empty_nxt(empty_nxt)
  );

  assign unused_araddr = ^s_axi_araddr[ADDR_W-2:0];
  assign accept    = (state_q == ST_IDLE) && arready_q && s_axi_arvalid;
  assign beat_done = (state_q == ST_BURST) && rvalid_q && s_axi_rready;
  assign beat_ok   = !mode_q && (rresp_q == RRESP_OKAY);
  assign flush     = (state_q == ST_IDLE) && !en;
  assign drop      = snap_valid && en && full;
  assign push      = snap_valid && en && !full;
  assign pop       = beat_done && beat_ok && (bp_q == BP_W'(BEATS - 1));
  assign nxt_mode  = accept ? s_axi_araddr[ADDR_W-1] : mode_q;
  assign head_pad  = (BEATS*DATA_W)'(head_nxt);
  assign stat_beat = DATA_W'(status_word(16'(drop_cnt_d), 16'(count_nxt), 16'(bp_d), FILL_W, BP_W));

  always_comb begin
    bp_d = bp_q;
    if (flush) bp_d = '0;
    else if (beat_done && beat_ok) bp_d = pop ? '0 : bp_q + BP_W'(1);
    drop_cnt_d  = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    snap_drop_d = drop;
  end

  // Each beat is registered from the state it will be presented in (next bp, next head).
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    rid_d     = rid_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (state_q == ST_IDLE) begin
      arready_d = 1'b1;
      if (accept) begin
        state_d   = ST_BURST;
        mode_d    = s_axi_araddr[ADDR_W-1];
        cnt_d     = s_axi_arlen;
        rid_d     = s_axi_arid;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rlast_d   = (s_axi_arlen == 8'd0);
      end
    end else if (beat_done) begin
      if (rlast_q) begin
        state_d   = ST_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end else begin
        cnt_d   = cnt_q - 8'd1;
        rlast_d = (cnt_q == 8'd1);
      end
    end
    if (accept || (beat_done && !rlast_q)) begin
      if (nxt_mode) begin
        rdata_d = stat_beat;
        rresp_d = RRESP_OKAY;
      end else if (empty_nxt) begin
        rdata_d = '0;
        rresp_d = RRESP_SLVERR;
      end else begin
        rdata_d = head_pad[int'(bp_d)*DATA_W +: DATA_W];
        rresp_d = RRESP_OKAY;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q <= ST_IDLE;     mode_q <= 1'b0;       cnt_q <= '0;
      bp_q <= '0;             drop_cnt_q <= '0;     snap_drop_q <= 1'b0;
      arready_q <= 1'b0;      rvalid_q <= 1'b0;     rlast_q <= 1'b0;
      rdata_q <= '0;          rresp_q <= '0;        rid_q <= '0;
    end else begin
      state_q <= state_d;     mode_q <= mode_d;     cnt_q <= cnt_d;
      bp_q <= bp_d;           drop_cnt_q <= drop_cnt_d; snap_drop_q <= snap_drop_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rdata_q <= rdata_d;     rresp_q <= rresp_d;   rid_q <= rid_d;
    end
  end

  assign snap_drop     = snap_drop_q;
  assign fill_level    = count;
  assign drop_cnt      = drop_cnt_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;

endmodule

// File: tb/tb_trace_snapshot_axi_reader.sv
// tb/tb_trace_snapshot_axi_reader.sv - randomized self-checking bench against a queue-based record model
module tb_trace_snapshot_axi_reader;
  localparam int REC_W = 1664, DATA_W = 128, DEPTH = 4, ADDR_W = 12, ID_W = 16;
  localparam int BEATS = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en, snap_valid, snap_drop;
  logic [REC_W-1:0] snap_data;
  logic [2:0] fill_level;
  logic [15:0] drop_cnt;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0] s_axi_arlen;
  logic [ID_W-1:0] s_axi_arid, s_axi_rid;
  logic s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;

  trace_snapshot_axi_reader dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .en(en), .snap_valid(snap_valid),
    .snap_data(snap_data), .snap_drop(snap_drop), .fill_level(fill_level), .drop_cnt(drop_cnt),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arid(s_axi_arid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [REC_W-1:0] model_q[$];
  int m_bp = 0;
  int m_drop = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    for (int i = 0; i < REC_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_recs(input int n);
    logic was_full;
    for (int i = 0; i < n; i++) begin
      snap_valid = 1'b1;
      snap_data  = rand_rec();
      was_full   = (model_q.size() >= DEPTH);
      tick;
      if (en) begin
        if (was_full) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        else model_q.push_back(snap_data);
      end
      check("snap_drop", DATA_W'(snap_drop), DATA_W'(en && was_full));
      check("fill_level", DATA_W'(fill_level), DATA_W'(model_q.size()));
      check("drop_cnt", DATA_W'(drop_cnt), DATA_W'(m_drop));
    end
    snap_valid = 1'b0;
  endtask

  task automatic exp_beat(input logic mode, output logic [DATA_W-1:0] d, output logic [1:0] r);
    logic [BEATS*DATA_W-1:0] pad;
    if (mode) begin
      d = (DATA_W'(m_drop) << 7) | (DATA_W'(model_q.size()) << 4) | DATA_W'(m_bp);
      r = 2'b00;
    end else if (model_q.size() == 0) begin
      d = '0;
      r = 2'b10;
    end else begin
      pad = '0;
      pad[REC_W-1:0] = model_q[0];
      d = DATA_W'(pad >> (m_bp * DATA_W));
      r = 2'b00;
    end
  endtask

  task automatic model_advance(input logic mode);
    if (!mode && model_q.size() > 0) begin
      if (m_bp == BEATS - 1) begin
        void'(model_q.pop_front());
        m_bp = 0;
      end else begin
        m_bp++;
      end
    end
  endtask

  task automatic run_burst(input logic mode, input int len, input int stall_pct, input int abort_beat);
    logic [DATA_W-1:0] ed;
    logic [1:0] er;
    logic [ID_W-1:0] id;
    logic rr;
    int beat = 0;
    int guard = 0;
    id = ID_W'($urandom);
    s_axi_arid    = id;
    s_axi_araddr  = mode ? 12'h800 : ADDR_W'($urandom_range(0, 12'h7FF));
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    check("arready_idle", DATA_W'(s_axi_arready), DATA_W'(1));
    tick;
    s_axi_arvalid = 1'b0;
    while (beat <= len && guard < 2000) begin
      guard++;
      exp_beat(mode, ed, er);
      check("rvalid", DATA_W'(s_axi_rvalid), DATA_W'(1));
      check("rdata", s_axi_rdata, ed);
      check("rresp", DATA_W'(s_axi_rresp), DATA_W'(er));
      check("rlast", DATA_W'(s_axi_rlast), DATA_W'(beat == len));
      check("rid", DATA_W'(s_axi_rid), DATA_W'(id));
      check("arready_busy", DATA_W'(s_axi_arready), DATA_W'(0));
      if (beat == abort_beat) begin
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        m_bp = 0;
        m_drop = 0;
        check("rst_rvalid", DATA_W'(s_axi_rvalid), DATA_W'(0));
        check("rst_rdata", s_axi_rdata, DATA_W'(0));
        check("rst_rlast", DATA_W'(s_axi_rlast), DATA_W'(0));
        check("rst_fill", DATA_W'(fill_level), DATA_W'(model_q.size()));
        check("rst_arready", DATA_W'(s_axi_arready), DATA_W'(0));
        return;
      end
      rr = ($urandom_range(0, 99) >= stall_pct);
      s_axi_rready = rr;
      tick;
      if (rr) begin
        model_advance(mode);
        beat++;
      end
    end
    s_axi_rready = 1'b0;
    check("burst_beats", DATA_W'(beat), DATA_W'(len + 1));
    check("rvalid_end", DATA_W'(s_axi_rvalid), DATA_W'(0));
    check("arready_end", DATA_W'(s_axi_arready), DATA_W'(1));
  endtask

  initial begin
    en = 1'b1; snap_valid = 1'b0; snap_data = '0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arid = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_arready", DATA_W'(s_axi_arready), DATA_W'(0));
    check("reset_rvalid", DATA_W'(s_axi_rvalid), DATA_W'(0));
    check("reset_rlast", DATA_W'(s_axi_rlast), DATA_W'(0));
    check("reset_rdata", s_axi_rdata, DATA_W'(0));
    check("reset_rresp", DATA_W'(s_axi_rresp), DATA_W'(0));
    check("reset_rid", DATA_W'(s_axi_rid), DATA_W'(0));
    check("reset_snap_drop", DATA_W'(snap_drop), DATA_W'(0));
    check("reset_fill", DATA_W'(fill_level), DATA_W'(0));
    check("reset_drop_cnt", DATA_W'(drop_cnt), DATA_W'(0));
    rst = 1'b0;
    tick;
    check("arready_after_reset", DATA_W'(s_axi_arready), DATA_W'(1));

    push_recs(1);
    run_burst(1'b0, 12, 0, -1);
    push_recs(1);
    run_burst(1'b0, 12, 50, -1);

    push_recs(6);
    check("overflow_fill", DATA_W'(fill_level), DATA_W'(4));
    check("overflow_drops", DATA_W'(drop_cnt), DATA_W'(2));
    for (int k = 0; k < 40 && model_q.size() > 0; k++) run_burst(1'b0, $urandom_range(0, 20), 30, -1);

    push_recs(1);
    run_burst(1'b0, 3, 0, -1);
    run_burst(1'b1, 0, 0, -1);
    run_burst(1'b0, 8, 20, -1);
    check("split_fill", DATA_W'(fill_level), DATA_W'(0));
    run_burst(1'b1, 0, 0, -1);

    run_burst(1'b0, 1, 0, -1);
    run_burst(1'b1, 0, 0, -1);

    push_recs(2);
    run_burst(1'b0, 5, 0, -1);
    en = 1'b0;
    tick;
    model_q.delete();
    m_bp = 0;
    check("flush_fill", DATA_W'(fill_level), DATA_W'(0));
    run_burst(1'b1, 0, 0, -1);
    en = 1'b1;

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 1) == 1) push_recs($urandom_range(1, 3));
      run_burst($urandom_range(0, 4) == 0, $urandom_range(0, 20), $urandom_range(0, 60), -1);
    end

    for (int k = 0; k < 40 && model_q.size() > 0; k++) run_burst(1'b0, 12, 0, -1);
    push_recs(1);
    run_burst(1'b0, 12, 0, 5);
    s_axi_rready = 1'b0;
    tick;
    check("held_reset_arready", DATA_W'(s_axi_arready), DATA_W'(0));
    rst = 1'b0;
    tick;
    check("release_arready", DATA_W'(s_axi_arready), DATA_W'(1));
    check("release_fill", DATA_W'(fill_level), DATA_W'(0));
    push_recs(1);
    run_burst(1'b0, 12, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
